// File: rtl/segment_scan_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// segment_scan_controller_if : load/value inputs and scan outputs of the
// seven-segment scan controller.  Rev 1.0
// ---------------------------------------------------------------------------
interface segment_scan_controller_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  lz_blank;
    logic [3:0]            bcd;
    logic [DIGITS-1:0]     digit_en;
    logic                  dp;
    logic                  frame_done;
    logic                  load_ack;

    modport master (
        output load, value, dp_in, lz_blank,
        input  bcd, digit_en, dp, frame_done, load_ack
    );

    modport slave (
        input  load, value, dp_in, lz_blank,
        output bcd, digit_en, dp, frame_done, load_ack
    );
endinterface
`default_nettype wire

// File: rtl/segment_scan_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// segment_scan_controller : double-buffered, time-multiplexed digit scanner
// with dead-time blanking and leading-zero suppression.  Rev 1.0
// ---------------------------------------------------------------------------
module segment_scan_controller #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    segment_scan_controller_if.slave  bus
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [4*DIGITS-1:0]   disp_q,     disp_d;
    logic [DIGITS-1:0]     disp_dp_q,  disp_dp_d;
    logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     pend_dp_q,  pend_dp_d;
    logic                  pend_q,     pend_d;
    logic                  lz_q,       lz_d;
    logic                  frame_done_q, frame_done_d;
    logic                  load_ack_q,   load_ack_d;

    logic                  cnt_end;
    logic                  idx_end;
    logic                  boundary;

    assign cnt_end  = (cnt_q == CNT_W'(PRESCALE - 1));
    assign idx_end  = (idx_q == IDX_W'(DIGITS - 1));
    assign boundary = cnt_end && idx_end;

    always_comb begin
        cnt_d        = cnt_end ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        disp_d       = disp_q;
        disp_dp_d    = disp_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_d       = pend_q;
        lz_d         = bus.lz_blank;
        frame_done_d = boundary;
        load_ack_d   = boundary && (pend_q || bus.load);

        if (cnt_end) begin
            idx_d = idx_end ? '0 : idx_q + IDX_W'(1);
        end

        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_in;
        end

        // At the frame boundary a same-edge load bypasses the pending buffer.
        if (boundary) begin
            pend_d = 1'b0;
            if (bus.load) begin
                disp_d    = bus.value;
                disp_dp_d = bus.dp_in;
            end else if (pend_q) begin
                disp_d    = pend_val_q;
                disp_dp_d = pend_dp_q;
            end
        end else if (bus.load) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_q       <= 1'b0;
            lz_q         <= 1'b0;
            frame_done_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_q       <= pend_d;
            lz_q         <= lz_d;
            frame_done_q <= frame_done_d;
            load_ack_q   <= load_ack_d;
        end
    end

    logic [DIGITS-1:0] suppress;
    logic [DIGITS-1:0] en;
    logic [3:0]        bcd_sel;
    logic              show;

    assign show = (cnt_q >= CNT_W'(BLANK));

    // Walk from the most significant digit down, tracking whether every
    // nibble seen so far is zero.
    always_comb begin : p_decode
        logic zero_run;
        zero_run = 1'b1;
        suppress = '0;
        en       = '0;
        bcd_sel  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_q[4*i +: 4] == 4'h0);
            if (i != 0) begin
                suppress[i] = lz_q && zero_run;
            end
            if (idx_q == IDX_W'(i)) begin
                bcd_sel = disp_q[4*i +: 4];
                en[i]   = show && !suppress[i];
            end
        end
    end

    assign bus.bcd        = bcd_sel;
    assign bus.digit_en   = en;
    assign bus.dp         = |(en & disp_dp_q);
    assign bus.frame_done = frame_done_q;
    assign bus.load_ack   = load_ack_q;

endmodule
`default_nettype wire

// File: doc/segment_scan_controller.md
# segment_scan_controller

Time-multiplexed scan controller that shares one `sevensegmentdecoder` across `DIGITS` common-enable seven-segment digits. It holds a double-buffered display value and steps through the digits at a programmable slot rate. For each digit it presents the digit's nibble on `bcd` for the decoder and drives a one-hot `digit_en` with a dead-time gap for anti-ghosting. New values are adopted only at frame boundaries, so no frame shows a torn value. It sits between whatever datapath produces the hex value and the board's decoder/digit drivers.

## Interface
- `DIGITS`, 4: digits scanned. Legal range 1..8.
- `PRESCALE`, 1000: clock cycles per digit slot. Must be at least 2.
- `BLANK`, 4: dead-time cycles at the start of each slot. Legal range 1..PRESCALE-1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  capture strobe for `value`/`dp_in`, sampled each rising edge.
- `value`  in  4*DIGITS  hex nibbles; digit i is `value[4i+3:4i]`, and digit 0 is the rightmost.
- `dp_in`  in  DIGITS  decimal point per digit.
- `lz_blank`  in  1  leading-zero suppression enable (level, sampled live).
- `bcd`  out  4  nibble of the current digit, to the decoder input.
- `digit_en`  out  DIGITS  one-hot active-high digit enable, or all-zero.
- `dp`  out  1  decimal point of the current digit, gated exactly like that digit's `digit_en` bit.
- `frame_done`  out  1  one-cycle pulse after each completed frame.
- `load_ack`  out  1  one-cycle pulse when a pending load has been adopted into the display.

## Operation
- **Scan state.**
  - `cnt` runs 0..PRESCALE-1, then wraps to 0 and advances `idx`.
  - `idx` runs 0..DIGITS-1, then wraps to 0.
  - The scan order is 0,1,…,DIGITS-1,0,…
- **Phases within a slot.**
  - Blank phase: `cnt` < BLANK. `digit_en`=0, `dp`=0, and `bcd` already shows digit `idx` so the decoder settles.
  - Show phase: `cnt` ≥ BLANK. `digit_en`=one-hot(`idx`) unless the digit is suppressed, and `dp`=`disp_dp[idx]` under the same gating.
- **Leading-zero suppression.** With `lz_blank`=1, digit i (i≥1) is suppressed when the displayed nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps `digit_en` and `dp` at 0 for the whole slot; `bcd` still carries its nibble.
- **Buffering.**
  - An edge with `load`=1 copies `value`/`dp_in` into the pending buffer and sets `pend`=1.
  - A later load in the same frame overwrites the pending data. Last load wins.
- **Frame boundary.** This is the edge where `cnt`=PRESCALE-1 and `idx`=DIGITS-1.
  - `frame_done` is set to 1 for the following cycle.
  - If `pend`=1 or `load`=1 on this edge, the display registers take the new data and `load_ack` is 1 for the following cycle.
  - When `load`=1 on this edge, the new data is the incoming `value`/`dp_in`, bypassing the pending buffer.
  - `pend` clears on this edge.
- **Output sourcing.** All outputs are decoded from registered state or are registers. There is no combinational path from any input to any output.

## Timing
- **Reset (asynchronous).** `cnt`=0, `idx`=0, display=0, `disp_dp`=0, `pend`=0, and the pending buffer=0.
  - Output values during reset: `bcd`=0, `digit_en`=0, `dp`=0, `frame_done`=0, `load_ack`=0.
- **First cycle after reset release.** This is slot cycle 0 of digit 0, in the blank phase.
- **Slot timing.** Each slot lasts exactly PRESCALE cycles.
  - `digit_en` is high for PRESCALE-BLANK cycles per slot.
  - There are never two `digit_en` bits high at once.
- **Frame period.** DIGITS*PRESCALE cycles.
  - The first `frame_done` is high during cycle DIGITS*PRESCALE after reset release, where cycle 0 is the first.
- **Load latency.** A load is visible starting at the digit-0 slot after the next frame boundary.
  - A load on the boundary edge itself is visible immediately in the next frame.
  - `load_ack` is never asserted without `frame_done`.
- **Reset mid-operation.** Any reset immediately forces the reset values above. The pending load is discarded and no `load_ack` is issued for it.
- **`lz_blank` changes** take effect on the cycle after the edge that samples them.

## Test plan
All scenarios use `DIGITS`=4, `PRESCALE`=8, `BLANK`=2.
- **Idle after reset, `lz_blank`=0.**
  - `digit_en` is 0001 in cycles 2–7, 0000 in cycles 8–9, 0010 in cycles 10–15, and so on.
  - `bcd`=0 throughout.
  - `frame_done`=1 only in cycle 32.
  - `load_ack` stays 0.
- **Load `value`=16'h12AF, `dp_in`=4'b0100 at cycle 5.**
  - Frame 1 still shows 0000.
  - `load_ack` and `frame_done` are both 1 in cycle 32.
  - In cycles 32–63, `bcd` is F, A, 2, 1 by slot.
  - `dp`=1 only in cycles 50–55.
- **`lz_blank`=1 with `value`=16'h0030.**
  - `digit_en` bits 3 and 2 never assert.
  - Digit 1 shows `bcd`=3 and digit 0 shows `bcd`=0.
  - With `value`=0000, only digit 0 is ever enabled.
- **Loads at cycles 3 (16'h1111) and 20 (16'h2222).**
  - Exactly one `load_ack`, in cycle 32.
  - 2222 is displayed from cycle 32.
- **`load`=1 with 16'hBEEF on the edge ending cycle 31.**
  - 16'hBEEF is displayed from cycle 32.
  - `load_ack`=1 in cycle 32.
  - No further ack in cycle 64.
- **Reset pulse at cycle 13 with a load pending.**
  - Outputs are 0 immediately.
  - After release, the scan restarts at digit 0 / cycle 0, showing 0000.
  - No `load_ack` follows.
